if_neuron: RTL and testbench

- Single integrate-and-fire (IF) spiking neuron with no leak.
- Each clock it adds the synaptic weights of all active input spikes to a membrane potential.
- When the potential reaches the threshold, it emits a one-cycle output spike and resets the potential.
- Used as the building block of the SNN layer arrays; inputs come from upstream spike sources or neurons.

---
 rtl/if_neuron.sv | 103 ++++++++++
 tb/tb_if_neuron.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_neuron.sv
// -----------------------------------------------------------------------------
// if_neuron
//   Integrate-and-fire spiking neuron with no leak. Every rising edge the
//   weights of all active input spikes are added to an unsigned membrane
//   potential (saturating, never wrapping). When the updated potential reaches
//   threshold_potential the neuron emits a one-cycle registered spike, reloads
//   reset_potential and, optionally, ignores its inputs for refractory_period
//   cycles.
//
// Ports
//   clk       : system clock, all state changes on the rising edge
//   rst       : asynchronous, active-low reset
//   spike_in  : [num_inputs-1:0] input spikes, bit i = synapse i fires
//   spike_out : registered output spike, high for exactly one cycle per fire
// -----------------------------------------------------------------------------
module if_neuron #(
  parameter int unsigned threshold_potential = 10,
  parameter int unsigned reset_potential     = 0,
  parameter int unsigned weight_size         = 4,
  parameter int unsigned num_inputs          = 1,
  parameter int unsigned init_weight         = 1,
  parameter int unsigned potential_width     = 16,
  parameter int unsigned refractory_period   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [num_inputs-1:0] spike_in,
  output logic                  spike_out
);

  localparam int unsigned sum_width  = potential_width + 1;
  // One extra bit over sum_width so potential + sum can never wrap before the
  // saturation check.
  localparam int unsigned next_width = potential_width + 2;
  localparam int unsigned refr_width =
    (refractory_period > 0) ? $clog2(refractory_period + 1) : 1;

  localparam logic [weight_size-1:0]     weight    = weight_size'(init_weight);
  localparam logic [potential_width-1:0] pot_max   = '1;
  localparam logic [potential_width-1:0] pot_reset = potential_width'(reset_potential);
  localparam logic [next_width-1:0]      thresh    = next_width'(threshold_potential);
  localparam logic [refr_width-1:0]      refr_load = refr_width'(refractory_period);

  logic [potential_width-1:0] pot_q, pot_d;
  logic [refr_width-1:0]      refr_q, refr_d;
  logic                       spike_q, spike_d;

  logic [sum_width-1:0]       syn_sum;
  logic [next_width-1:0]      raw_next;
  logic [potential_width-1:0] sat_next;
  logic                       fire;

  // Synaptic sum: every synapse carries the same elaboration-time weight.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    syn_sum = '0;
    for (int i = 0; i < int'(num_inputs); i++) begin
      if (spike_in[i]) syn_sum = syn_sum + sum_width'(weight);
    end
  end

  // Integrate with saturation at the top of the potential range.
  always_comb begin
    raw_next = {2'b00, pot_q} + {1'b0, syn_sum};
    sat_next = (raw_next > {2'b00, pot_max}) ? pot_max : raw_next[potential_width-1:0];
    fire     = ({2'b00, sat_next} >= thresh);
  end

  // Next-state: refractory cycles freeze the potential and drain the counter;
  // otherwise integrate and fire at most once, discarding any overshoot.
  always_comb begin
    pot_d   = pot_q;
    refr_d  = refr_q;
    spike_d = 1'b0;
    if (refr_q != '0) begin
      refr_d = refr_q - 1'b1;
    end else if (fire) begin
      spike_d = 1'b1;
      pot_d   = pot_reset;
      refr_d  = refr_load;
    end else begin
      pot_d   = sat_next;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pot_q   <= pot_reset;
      refr_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      pot_q   <= pot_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out = spike_q;

endmodule

// File: tb/tb_if_neuron.sv
// -----------------------------------------------------------------------------
// tb_if_neuron
//   Directed bench for if_neuron. Five instances share clk/rst:
//     u_dflt  : default parameters
//     u_multi : 4 inputs, weight 3
//     u_sat   : 4-bit potential, threshold 15, weight 9 (second add saturates)
//     u_refr  : refractory_period 3
//     u_zero  : threshold 0 == reset 0, fires on every cycle
//   Outputs are sampled 1 time unit after each rising edge; inputs are driven
//   at that same point, well before the next edge.
// -----------------------------------------------------------------------------
module tb_if_neuron;

  logic       clk;
  logic       rst;
  logic       s1;
  logic [3:0] s4;
  logic       spk_dflt, spk_multi, spk_sat, spk_refr, spk_zero;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic spk;
    logic exp_dflt;
  } vec_t;

  vec_t hold_tbl[31];

  if_neuron u_dflt (
    .clk(clk), .rst(rst), .spike_in(s1), .spike_out(spk_dflt)
  );

  if_neuron #(.num_inputs(4), .init_weight(3)) u_multi (
    .clk(clk), .rst(rst), .spike_in(s4), .spike_out(spk_multi)
  );

  if_neuron #(.potential_width(4), .threshold_potential(15), .init_weight(9)) u_sat (
    .clk(clk), .rst(rst), .spike_in(s1), .spike_out(spk_sat)
  );

  if_neuron #(.refractory_period(3)) u_refr (
    .clk(clk), .rst(rst), .spike_in(s1), .spike_out(spk_refr)
  );

  if_neuron #(.threshold_potential(0), .reset_potential(0)) u_zero (
    .clk(clk), .rst(rst), .spike_in(s1), .spike_out(spk_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; reset pulse ends before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int pulses_d;
    int pulses_r;

    rst = 1'b0;
    s1  = 1'b1;
    s4  = 4'hf;

    // Reset held with active inputs: nothing fires.
    for (int n = 0; n < 5; n++) begin
      step();
      check("rst_hold_dflt", spk_dflt, 1'b0);
      check("rst_hold_zero", spk_zero, 1'b0);
    end

    // Release; first fire on exactly the 10th edge, one cycle wide.
    rst = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("start_dflt",  spk_dflt,  n == 10);
      check("start_refr",  spk_refr,  n == 10);
      check("start_multi", spk_multi, 1'b1);
      check("start_sat",   spk_sat,   (n % 2) == 0);
      check("start_zero",  spk_zero,  1'b1);
    end

    // Periodic firing over 100 cycles; refractory instance has period 13.
    do_reset();
    pulses_d = 0;
    pulses_r = 0;
    for (int n = 1; n <= 100; n++) begin
      step();
      check("period_dflt", spk_dflt, (n % 10) == 0);
      check("period_refr", spk_refr, (n >= 10) && ((n - 10) % 13 == 0));
      if (spk_dflt) pulses_d++;
      if (spk_refr) pulses_r++;
    end
    check("period_dflt_count", pulses_d == 10, 1'b1);
    check("period_refr_count", pulses_r == 7, 1'b1);

    // Hold / no leak: 6 active, 20 idle, then fire on the 4th active cycle.
    for (int i = 0; i < 6; i++)  hold_tbl[i] = '{1'b1, 1'b0};
    for (int i = 6; i < 26; i++) hold_tbl[i] = '{1'b0, 1'b0};
    for (int i = 26; i < 29; i++) hold_tbl[i] = '{1'b1, 1'b0};
    hold_tbl[29] = '{1'b1, 1'b1};
    hold_tbl[30] = '{1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 31; i++) begin
      s1 = hold_tbl[i].spk;
      step();
      check("hold_dflt", spk_dflt, hold_tbl[i].exp_dflt);
      check("hold_refr", spk_refr, hold_tbl[i].exp_dflt);
      // Fires with or without input when threshold <= reset potential.
      check("hold_zero", spk_zero, 1'b1);
    end

    // Multi-input partial activity: one input (sum 3) then two inputs (sum 6).
    do_reset();
    s4 = 4'b0100;
    for (int n = 1; n <= 4; n++) begin
      step();
      check("multi_one", spk_multi, n == 4);
    end
    s4 = 4'b0011;
    for (int n = 1; n <= 3; n++) begin
      step();
      check("multi_two", spk_multi, n == 2);
    end
    s4 = 4'b0000;
    for (int n = 1; n <= 3; n++) begin
      step();
      check("multi_idle", spk_multi, 1'b0);
    end

    // Async reset mid-integration: accumulate 7, pulse rst between edges.
    do_reset();
    s1 = 1'b1;
    s4 = 4'hf;
    for (int n = 1; n <= 7; n++) begin
      step();
      check("pre_areset_dflt", spk_dflt, 1'b0);
    end
    check("pre_areset_zero", spk_zero, 1'b1);
    check("pre_areset_multi", spk_multi, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("areset_zero_drop",  spk_zero,  1'b0);
    check("areset_multi_drop", spk_multi, 1'b0);
    check("areset_dflt",       spk_dflt,  1'b0);
    #1;
    rst = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      step();
      check("post_areset_dflt", spk_dflt, n == 10);
      check("post_areset_zero", spk_zero, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
